// File: rtl/countdown_timer.sv
// Countdown timer mode: keys load a d:h:m:s value, then it counts down once per 1 Hz tick and raises an alarm at zero.
// Latency: a key edge acts on the clk edge that first samples it high; a tick acts in the clk it is sampled.
// Backpressure: none; keys and ticks are single-cycle events, and events arriving in an ignoring state are dropped.
module countdown_timer #(
  parameter int DAY_MAX       = 31,
  parameter int ALARM_SECONDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       tmr_mode,
  input  logic       key_start_stop,
  input  logic       key_field,
  input  logic       key_inc,
  output logic [5:0] tm_seconds,
  output logic [5:0] tm_minutes,
  output logic [4:0] tm_hours,
  output logic [4:0] tm_days,
  output logic [1:0] field_sel,
  output logic       running,
  output logic       alarm
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  localparam int         CW         = (ALARM_SECONDS > 1) ? $clog2(ALARM_SECONDS) : 1;
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_SECONDS - 1);
  localparam logic [4:0] DAY_LAST   = 5'(DAY_MAX);

  logic [1:0]    state, state_nxt;
  logic [5:0]    sec_nxt, min_nxt;
  logic [4:0]    hr_nxt, day_nxt;
  logic [1:0]    sel_nxt;
  logic [CW-1:0] alarm_cnt, cnt_nxt;

  logic start_prev, field_prev, inc_prev;
  logic ev_start, ev_field, ev_inc, ev_any;
  logic all_zero, is_one;

  // Key events fire on release (low-to-high), one clk wide.
  assign ev_start = ~start_prev & key_start_stop;
  assign ev_field = ~field_prev & key_field;
  assign ev_inc   = ~inc_prev   & key_inc;
  assign ev_any   = ev_start | ev_field | ev_inc;

  assign all_zero = (tm_days == 5'd0) && (tm_hours == 5'd0) &&
                    (tm_minutes == 6'd0) && (tm_seconds == 6'd0);
  assign is_one   = (tm_days == 5'd0) && (tm_hours == 5'd0) &&
                    (tm_minutes == 6'd0) && (tm_seconds == 6'd1);

  // Next-state, field and alarm-counter decode for all four modes.
  always_comb begin
    state_nxt = state;
    sec_nxt   = tm_seconds;
    min_nxt   = tm_minutes;
    hr_nxt    = tm_hours;
    day_nxt   = tm_days;
    sel_nxt   = field_sel;
    cnt_nxt   = alarm_cnt;

    case (state)
      ST_IDLE: begin
        // Start wins over editing keys if several are released together.
        if (ev_start) begin
          if (!all_zero) state_nxt = ST_RUN;
        end else if (ev_field) begin
          sel_nxt = field_sel + 2'd1;
        end else if (ev_inc) begin
          case (field_sel)
            2'd0:    sec_nxt = (tm_seconds == 6'd59) ? 6'd0 : tm_seconds + 6'd1;
            2'd1:    min_nxt = (tm_minutes == 6'd59) ? 6'd0 : tm_minutes + 6'd1;
            2'd2:    hr_nxt  = (tm_hours   == 5'd23) ? 5'd0 : tm_hours + 5'd1;
            default: day_nxt = (tm_days >= DAY_LAST) ? 5'd0 : tm_days + 5'd1;
          endcase
        end
      end

      ST_RUN: begin
        // The key beats a coincident tick; that tick is deliberately lost.
        if (ev_start) begin
          state_nxt = ST_PAUSE;
        end else if (tick_1hz) begin
          if (is_one || all_zero) begin
            sec_nxt   = 6'd0;
            min_nxt   = 6'd0;
            hr_nxt    = 5'd0;
            day_nxt   = 5'd0;
            state_nxt = ST_ALARM;
          end else if (tm_seconds != 6'd0) begin
            sec_nxt = tm_seconds - 6'd1;
          end else begin
            sec_nxt = 6'd59;
            if (tm_minutes != 6'd0) begin
              min_nxt = tm_minutes - 6'd1;
            end else begin
              min_nxt = 6'd59;
              if (tm_hours != 5'd0) begin
                hr_nxt = tm_hours - 5'd1;
              end else begin
                hr_nxt  = 5'd23;
                day_nxt = tm_days - 5'd1;
              end
            end
          end
        end
      end

      ST_PAUSE: begin
        if (ev_start) begin
          state_nxt = ST_RUN;
        end else if (ev_field) begin
          state_nxt = ST_IDLE;
          sel_nxt   = 2'd0;
        end
      end

      ST_ALARM: begin
        sec_nxt = 6'd0;
        min_nxt = 6'd0;
        hr_nxt  = 5'd0;
        day_nxt = 5'd0;
        if (ev_any) begin
          state_nxt = ST_IDLE;
          sel_nxt   = 2'd0;
        end else if (tick_1hz) begin
          if (alarm_cnt == ALARM_LAST) begin
            state_nxt = ST_IDLE;
            sel_nxt   = 2'd0;
          end else begin
            cnt_nxt = alarm_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        sel_nxt   = 2'd0;
      end
    endcase

    // The alarm tick counter only lives inside ALARM, so it starts fresh on each entry.
    if (state_nxt != ST_ALARM) cnt_nxt = '0;
  end

  // State, fields and the registered running/alarm decodes; tmr_mode low holds everything cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      tm_seconds <= 6'd0;
      tm_minutes <= 6'd0;
      tm_hours   <= 5'd0;
      tm_days    <= 5'd0;
      field_sel  <= 2'd0;
      alarm_cnt  <= '0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      start_prev <= 1'b1;
      field_prev <= 1'b1;
      inc_prev   <= 1'b1;
    end else if (!tmr_mode) begin
      state      <= ST_IDLE;
      tm_seconds <= 6'd0;
      tm_minutes <= 6'd0;
      tm_hours   <= 5'd0;
      tm_days    <= 5'd0;
      field_sel  <= 2'd0;
      alarm_cnt  <= '0;
      running    <= 1'b0;
      alarm      <= 1'b0;
      start_prev <= 1'b1;
      field_prev <= 1'b1;
      inc_prev   <= 1'b1;
    end else begin
      state      <= state_nxt;
      tm_seconds <= sec_nxt;
      tm_minutes <= min_nxt;
      tm_hours   <= hr_nxt;
      tm_days    <= day_nxt;
      field_sel  <= sel_nxt;
      alarm_cnt  <= cnt_nxt;
      running    <= (state_nxt == ST_RUN);
      alarm      <= (state_nxt == ST_ALARM);
      start_prev <= key_start_stop;
      field_prev <= key_field;
      inc_prev   <= key_inc;
    end
  end

endmodule
